// File: rtl/switch_arb.sv
// switch_arb: round-robin arbiter that lets four requesters toggle one shared
// switch, with a fixed hold-off window after every toggle.
module switch_arb #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_sclr,
  input  logic [3:0] i_req,
  output logic       o_sw,
  output logic       o_en,
  output logic [3:0] o_gnt,
  output logic       o_busy,
  output logic [3:0] o_pend
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] req_d;
  logic [3:0] rise;
  logic [3:0] pend_nx;
  logic [3:0] clr;
  logic [3:0] gnt_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [1:0] ptr;
  logic [1:0] ptr_nx;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       sw_nx;
  logic       en_nx;

  assign rise   = i_req & ~req_d;
  assign o_busy = (state == S_HOLD);

  // The edge history keeps running through a synchronous clear.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_d <= 4'b0000;
    end else begin
      req_d <= i_req;
    end
  end

  // Search starts just after the last winner; offset 4 wraps back to ptr itself.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && o_pend[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    sw_nx    = o_sw;
    en_nx    = 1'b0;
    gnt_nx   = 4'b0000;
    clr      = 4'b0000;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nx = S_HOLD;
          cnt_nx   = 4'(HOLD);
          ptr_nx   = pick;
          sw_nx    = ~o_sw;
          en_nx    = 1'b1;
          gnt_nx   = 4'(1) << pick;
          clr      = 4'(1) << pick;
        end
      end
      S_HOLD: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // A new rising edge beats the clear of the bit just granted.
    pend_nx = (o_pend & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      ptr    <= 2'd3;
      o_sw   <= 1'b0;
      o_en   <= 1'b0;
      o_gnt  <= 4'b0000;
      o_pend <= 4'b0000;
    end else if (i_sclr) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      ptr    <= 2'd3;
      o_sw   <= 1'b0;
      o_en   <= 1'b0;
      o_gnt  <= 4'b0000;
      o_pend <= 4'b0000;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      o_sw   <= sw_nx;
      o_en   <= en_nx;
      o_gnt  <= gnt_nx;
      o_pend <= pend_nx;
    end
  end

endmodule
